// File: rtl/acl_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register map; miso follows an sclk fall within SYNC_STAGES cycles.
// Optional ACL_RESP_SOFTRESET_EN: writing 8'h52 to 0x1F clears the control registers and sample state.
module acl_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic               clk_100mhz,
  input  logic               rst,
  input  logic               sclk,
  input  logic               csn,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic signed [11:0] x,
  input  logic signed [11:0] y,
  input  logic signed [11:0] z,
  input  logic               sample_valid,
  output logic [7:0]         power_ctl,
  output logic               measure
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_DROP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_s_q, csn_s_q, mosi_s_q;
  logic                   sclk_rise, sclk_fall, csn_fall, csn_rise, byte_done, soft_rst;
  logic [7:0]             byte_in, rdata, sr_q, tx_q;
  logic [2:0]             cnt_q;
  logic [5:0]             addr_q;
  logic                   cmd_rd_q, wr_stb_q, rd_flag_q, miso_q, oe_q, dr_q, pend_q;
  logic [11:0]            sx_q, sy_q, sz_q, px_q, py_q, pz_q;
  logic [7:0]             ctl_q [15];

  // csn chain resets low so a select held across reset never looks like a fresh csn fall
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sclk_s_q <= '0;
      csn_s_q  <= '0;
      mosi_s_q <= '0;
    end else begin
      sclk_s_q <= {sclk_s_q[SYNC_STAGES-2:0], sclk};
      csn_s_q  <= {csn_s_q[SYNC_STAGES-2:0], csn};
      mosi_s_q <= {mosi_s_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_rise = sclk_s_q[SYNC_STAGES-2] & ~sclk_s_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_s_q[SYNC_STAGES-2] & sclk_s_q[SYNC_STAGES-1];
  assign csn_fall  = ~csn_s_q[SYNC_STAGES-2] & csn_s_q[SYNC_STAGES-1];
  assign csn_rise  = csn_s_q[SYNC_STAGES-2] & ~csn_s_q[SYNC_STAGES-1];
  assign byte_in   = {sr_q[6:0], mosi_s_q[SYNC_STAGES-1]};
  assign byte_done = sclk_rise && (cnt_q == 3'd7);

`ifdef ACL_RESP_SOFTRESET_EN
  assign soft_rst = wr_stb_q && (addr_q == 6'h1F) && (sr_q == 8'h52);
`else
  assign soft_rst = 1'b0;
`endif

  always_ff @(posedge clk_100mhz) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (csn_fall) state_d = S_CMD;
      S_CMD:   if (byte_done) state_d = (byte_in == 8'h0B || byte_in == 8'h0A) ? S_ADDR : S_DROP;
      S_ADDR:  if (byte_done) state_d = cmd_rd_q ? S_RD : S_WR;
      default: ;
    endcase
    if (csn_rise) state_d = S_IDLE;
  end

  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      6'h00: rdata = DEVID_AD;
      6'h01: rdata = DEVID_MST;
      6'h02: rdata = PARTID;
      6'h03: rdata = 8'h02;
      6'h08: rdata = sx_q[11:4];
      6'h09: rdata = sy_q[11:4];
      6'h0A: rdata = sz_q[11:4];
      6'h0B: rdata = {7'b0, dr_q};
      6'h0E: rdata = sx_q[7:0];
      6'h0F: rdata = {{4{sx_q[11]}}, sx_q[11:8]};
      6'h10: rdata = sy_q[7:0];
      6'h11: rdata = {{4{sy_q[11]}}, sy_q[11:8]};
      6'h12: rdata = sz_q[7:0];
      6'h13: rdata = {{4{sz_q[11]}}, sz_q[11:8]};
      default: if (addr_q[5:4] == 2'b10 && addr_q[3:0] != 4'hF) rdata = ctl_q[addr_q[3:0]];
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt_q     <= '0;
      sr_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      cmd_rd_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_flag_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      dr_q      <= 1'b0;
      pend_q    <= 1'b0;
      {sx_q, sy_q, sz_q} <= '0;
      {px_q, py_q, pz_q} <= '0;
      for (int i = 0; i < 15; i++) ctl_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (csn_fall) begin
        oe_q      <= 1'b1;
        cnt_q     <= '0;
        rd_flag_q <= 1'b0;
      end
      if (sclk_rise && (state_q inside {S_CMD, S_ADDR, S_WR})) begin
        sr_q  <= byte_in;
        cnt_q <= cnt_q + 3'd1;
      end
      if (byte_done && state_q == S_CMD)  cmd_rd_q <= (byte_in == 8'h0B);
      if (byte_done && state_q == S_ADDR) addr_q   <= byte_in[5:0];
      if (byte_done && state_q == S_WR)   wr_stb_q <= 1'b1;
      if (wr_stb_q) begin
        if (addr_q[5:4] == 2'b10 && addr_q[3:0] != 4'hF) ctl_q[addr_q[3:0]] <= sr_q;
        addr_q <= addr_q + 6'd1;
      end
      // A read byte is fetched on the first fall of each 8-fall group; the rest shift it out
      if (state_q == S_RD && sclk_fall) begin
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'd0) begin
          miso_q <= rdata[7];
          tx_q   <= {rdata[6:0], 1'b0};
          addr_q <= addr_q + 6'd1;
          if (addr_q == 6'h08 || addr_q == 6'h0E) rd_flag_q <= 1'b1;
        end else begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
      end else if (state_q != S_RD) begin
        miso_q <= 1'b0;
      end
      if (csn_rise) begin
        oe_q   <= 1'b0;
        miso_q <= 1'b0;
        cnt_q  <= '0;
      end
      if (soft_rst) begin
        for (int i = 0; i < 15; i++) ctl_q[i] <= '0;
        {sx_q, sy_q, sz_q} <= '0;
        pend_q <= 1'b0;
        dr_q   <= 1'b0;
      end
      if (csn_rise) begin
        if (rd_flag_q) dr_q <= 1'b0;
        if (pend_q) begin
          {sx_q, sy_q, sz_q} <= {px_q, py_q, pz_q};
          dr_q   <= 1'b1;
          pend_q <= 1'b0;
        end
      end
      // A sample arriving on the closing csn edge is newer than anything pending
      if (sample_valid) begin
        if (state_q == S_IDLE || csn_rise) begin
          {sx_q, sy_q, sz_q} <= {x, y, z};
          dr_q <= 1'b1;
        end else begin
          {px_q, py_q, pz_q} <= {x, y, z};
          pend_q <= 1'b1;
        end
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign power_ctl = ctl_q[13];
  assign measure   = (ctl_q[13][1:0] == 2'b10);

endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed bench for acl_spi_responder: a table of SPI transactions with hand-computed
// responses, followed by sequences for pending samples, aborted writes and reset mid-transfer.
module tb_acl_spi_responder;
  localparam int HALF = 10;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    int          n;
    logic [47:0] wdat;
    logic        rd;
    logic [47:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, sclk, csn, mosi, miso, miso_oe, sample_valid, measure;
  logic [11:0] x, y, z;
  logic [7:0]  power_ctl;
  int          nvec = 0;
  int          nfail = 0;
  int          oe_err = 0;
  vec_t        vt [14];

  always #5 clk = ~clk;

  acl_spi_responder dut (
    .clk_100mhz(clk), .rst(rst), .sclk(sclk), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .x(x), .y(y), .z(z),
    .sample_valid(sample_valid), .power_ctl(power_ctl), .measure(measure)
  );

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      mosi = d[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      r[i] = miso;
      if (miso_oe !== 1'b1) oe_err++;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic begin_txn();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_txn();
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                      input logic [47:0] wd, output logic [47:0] rx);
    logic [7:0] b;
    rx = '0;
    begin_txn();
    spi_bits(cmd, 8, b);
    spi_bits(addr, 8, b);
    for (int k = 0; k < n; k++) begin
      spi_bits(wd[47-8*k -: 8], 8, b);
      rx[47-8*k -: 8] = b;
    end
    end_txn();
  endtask

  task automatic pulse_sample(input logic [11:0] xs, input logic [11:0] ys, input logic [11:0] zs);
    @(negedge clk);
    x = xs; y = ys; z = zs;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [47:0] rx;
    logic [7:0]  b;

    vt[0]  = '{8'h0B, 8'h00, 4, 48'h0,            1'b1, 48'hAD1DF2020000};
    vt[1]  = '{8'h0B, 8'h0E, 6, 48'h0,            1'b1, 48'h230180FFFF07};
    vt[2]  = '{8'h0B, 8'h08, 4, 48'h0,            1'b1, 48'h12F87F000000};
    vt[3]  = '{8'h0A, 8'h2D, 1, 48'h020000000000, 1'b0, 48'h0};
    vt[4]  = '{8'h0B, 8'h2D, 1, 48'h0,            1'b1, 48'h020000000000};
    vt[5]  = '{8'h0B, 8'h3F, 2, 48'h0,            1'b1, 48'h00AD00000000};
    vt[6]  = '{8'h0A, 8'h20, 3, 48'hA55A3C000000, 1'b0, 48'h0};
    vt[7]  = '{8'h0B, 8'h1F, 5, 48'h0,            1'b1, 48'h00A55A3C0000};
    vt[8]  = '{8'h0A, 8'h0B, 1, 48'hFF0000000000, 1'b0, 48'h0};
    vt[9]  = '{8'h0B, 8'h0A, 2, 48'h0,            1'b1, 48'h7F0000000000};
    vt[10] = '{8'h0A, 8'h2E, 2, 48'h776600000000, 1'b0, 48'h0};
    vt[11] = '{8'h0B, 8'h2E, 2, 48'h0,            1'b1, 48'h770000000000};
    vt[12] = '{8'h0D, 8'h00, 2, 48'h0,            1'b1, 48'h000000000000};
    vt[13] = '{8'h0B, 8'h10, 2, 48'h0,            1'b1, 48'h80FF00000000};

    rst = 1'b1; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
    sample_valid = 1'b0; x = '0; y = '0; z = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_miso", 48'(miso), 48'h0);
    chk("reset_miso_oe", 48'(miso_oe), 48'h0);
    chk("reset_power_ctl", 48'(power_ctl), 48'h0);
    chk("reset_measure", 48'(measure), 48'h0);

    pulse_sample(12'h123, 12'hF80, 12'h7FF);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].cmd, vt[i].addr, vt[i].n, vt[i].wdat, rx);
      if (vt[i].rd) chk($sformatf("vec%0d_cmd%0h_addr%0h", i, vt[i].cmd, vt[i].addr), rx, vt[i].exp);
    end
    chk("idle_miso_oe", 48'({miso_oe, miso}), 48'h0);
    chk("power_ctl", 48'(power_ctl), 48'h02);
    chk("measure", 48'(measure), 48'h1);

    // sample arriving mid-read is held until the transaction closes
    begin_txn();
    spi_bits(8'h0B, 8, b);
    spi_bits(8'h08, 8, b);
    pulse_sample(12'hABC, 12'h456, 12'h800);
    spi_bits(8'h00, 8, b);
    end_txn();
    chk("pending_old_x", 48'(b), 48'h12);
    xfer(8'h0B, 8'h08, 4, 48'h0, rx);
    chk("pending_applied", rx, 48'hAB4580010000);
    xfer(8'h0B, 8'h0B, 1, 48'h0, rx);
    chk("status_cleared", rx, 48'h0);
    xfer(8'h0B, 8'h12, 2, 48'h0, rx);
    chk("z_low_high", rx, 48'h00F800000000);

    // write aborted after 5 data bits must leave the register untouched
    begin_txn();
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h20, 8, b);
    spi_bits(8'h0F, 5, b);
    end_txn();
    chk("abort_miso_oe", 48'({miso_oe, miso}), 48'h0);
    xfer(8'h0B, 8'h20, 1, 48'h0, rx);
    chk("abort_no_write", rx, 48'hA50000000000);
    chk("oe_during_txn", 48'(oe_err), 48'h0);

    // reset in the middle of a write: everything returns to reset values
    begin_txn();
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h2D, 8, b);
    spi_bits(8'hFF, 4, b);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    spi_bits(8'hF0, 4, b);
    end_txn();
    chk("rst_power_ctl", 48'(power_ctl), 48'h0);
    chk("rst_measure", 48'(measure), 48'h0);
    xfer(8'h0B, 8'h00, 1, 48'h0, rx);
    chk("rst_devid", rx, 48'hAD0000000000);
    xfer(8'h0B, 8'h08, 4, 48'h0, rx);
    chk("rst_snapshot", rx, 48'h0);
    xfer(8'h0B, 8'h20, 1, 48'h0, rx);
    chk("rst_ctl", rx, 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
